// File: rtl/divisor_secuencial.sv
// divisor_secuencial
// Sequential unsigned restoring divider. One quotient bit is resolved per
// clock edge, so a division takes N+1 edges from the accepting edge until
// fin goes high.
//
// Optional feature: define DIV_ZERO_DETECT_EN to short-circuit division by
// zero. The accepting edge then goes straight to DONE with div0=1. Without
// the macro, div0 is tied low and a zero divisor runs the normal sequence.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      request, accepted in IDLE or DONE
//   dividendo  unsigned dividend, latched on an accepted start
//   divisor    unsigned divisor, latched on an accepted start
//   cociente   registered quotient
//   resto      registered remainder
//   busy       high while iterating
//   fin        high while cociente/resto hold a valid result
//   div0       divide-by-zero flag
//
// state | meaning
// IDLE  | after reset, waiting for start, outputs at reset value
// ITER  | one restoring step per edge, counter counts down from N
// DONE  | result valid, waiting for the next start
module divisor_secuencial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] cociente,
    output logic [N-1:0] resto,
    output logic         busy,
    output logic         fin,
    output logic         div0
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    localparam int CW = $clog2(N + 1);

    state_t        state;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  r_reg;
    logic [N-1:0]  d_reg;
    logic [CW-1:0] cnt;

    logic [N:0]    trial;
    logic [N-1:0]  q_next;
    logic [N-1:0]  r_next;

    // Restoring step. The trial subtraction is one bit wider than the
    // operands so that its MSB is a clean borrow even for all-ones inputs.
    always_comb begin
        trial = {r_reg, q_reg[N-1]} - {1'b0, d_reg};
        if (!trial[N]) begin
            r_next = trial[N-1:0];
            q_next = {q_reg[N-2:0], 1'b1};
        end else begin
            r_next = {r_reg[N-2:0], q_reg[N-1]};
            q_next = {q_reg[N-2:0], 1'b0};
        end
    end

`ifndef DIV_ZERO_DETECT_EN
    assign div0 = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            q_reg    <= '0;
            r_reg    <= '0;
            d_reg    <= '0;
            cnt      <= '0;
            cociente <= '0;
            resto    <= '0;
            busy     <= 1'b0;
            fin      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            div0     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        q_reg <= dividendo;
                        d_reg <= divisor;
                        r_reg <= '0;
                        cnt   <= CW'(N);
`ifdef DIV_ZERO_DETECT_EN
                        if (divisor == '0) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            fin      <= 1'b1;
                            cociente <= '1;
                            resto    <= dividendo;
                            div0     <= 1'b1;
                        end else begin
                            state <= ITER;
                            busy  <= 1'b1;
                            fin   <= 1'b0;
                            div0  <= 1'b0;
                        end
`else
                        state <= ITER;
                        busy  <= 1'b1;
                        fin   <= 1'b0;
`endif
                    end
                end
                ITER: begin
                    // start is deliberately ignored here
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        fin      <= 1'b1;
                        cociente <= q_next;
                        resto    <= r_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    fin   <= 1'b0;
                end
            endcase
        end
    end

endmodule
